// File: rtl/axil_reg_bank_if.sv
// AXI-Lite bus bundle shared by the interconnect and its register-bank endpoints.
interface axilite_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DWIDTH-1:0]   wdata;
  logic [DWIDTH/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [AWIDTH-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DWIDTH-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI-Lite CSR endpoint: NUM_RW byte-writable control words followed by NUM_RO
// status words sampled from fabric when the read address is accepted.
module axil_reg_bank #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int NUM_RW = 8,
  parameter int NUM_RO = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  axilite_if.slave                                     s_axil,
  output logic [NUM_RW*DWIDTH-1:0]                     ctrl_o,
  output logic [NUM_RW-1:0]                            wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DWIDTH-1:0] stat_i
);
  localparam int ADDR_LSB = $clog2(DWIDTH / 8);
  localparam int IW       = AWIDTH - ADDR_LSB;
  localparam int SB       = DWIDTH / 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef logic [IW-1:0] idx_t;

  logic              ready_reg;
  logic              aw_held_reg, w_held_reg;
  logic [AWIDTH-1:0] awaddr_reg;
  logic [DWIDTH-1:0] wdata_reg;
  logic [SB-1:0]     wstrb_reg;
  logic              bvalid_reg;
  logic [1:0]        bresp_reg;
  logic              rvalid_reg;
  logic [DWIDTH-1:0] rdata_reg;
  logic [1:0]        rresp_reg;

  logic              awready_int, wready_int, arready_int;
  logic              aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic [SB-1:0]     wr_strb;
  idx_t              widx, ridx;
  logic              rd_hit;
  logic [DWIDTH-1:0] rd_value;
  logic              unused_bits;

  // ready_reg keeps every ready low until the first edge after reset release
  assign awready_int = ready_reg && !aw_held_reg;
  assign wready_int  = ready_reg && !w_held_reg;
  assign arready_int = ready_reg && !rvalid_reg;

  assign aw_hs = s_axil.awvalid && awready_int;
  assign w_hs  = s_axil.wvalid && wready_int;
  assign ar_hs = s_axil.arvalid && arready_int;

  assign wr_addr = aw_held_reg ? awaddr_reg : s_axil.awaddr;
  assign wr_data = w_held_reg ? wdata_reg : s_axil.wdata;
  assign wr_strb = w_held_reg ? wstrb_reg : s_axil.wstrb;
  assign commit  = (aw_held_reg || aw_hs) && (w_held_reg || w_hs) && !bvalid_reg;

  assign widx   = wr_addr[AWIDTH-1:ADDR_LSB];
  assign ridx   = s_axil.araddr[AWIDTH-1:ADDR_LSB];
  assign wr_ok  = widx < idx_t'(NUM_RW);
  assign rd_hit = ridx < idx_t'(NUM_RW + NUM_RO);

  assign unused_bits = &{1'b0, wr_addr[ADDR_LSB-1:0], s_axil.araddr[ADDR_LSB-1:0]};

  assign s_axil.awready = awready_int;
  assign s_axil.wready  = wready_int;
  assign s_axil.arready = arready_int;
  assign s_axil.bvalid  = bvalid_reg;
  assign s_axil.bresp   = bresp_reg;
  assign s_axil.rvalid  = rvalid_reg;
  assign s_axil.rdata   = rdata_reg;
  assign s_axil.rresp   = rresp_reg;

  generate
    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw
      logic [DWIDTH-1:0] val_reg;
      logic              pulse_reg;
      logic              sel;

      assign sel = commit && wr_ok && (widx == idx_t'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          val_reg   <= '0;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= sel;
          if (sel) begin
            for (int b = 0; b < SB; b++) begin
              if (wr_strb[b]) val_reg[8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end

      assign ctrl_o[gi*DWIDTH +: DWIDTH] = val_reg;
      assign wr_pulse[gi]                = pulse_reg;
    end
  endgenerate

  // Reads see the registered control value, so a same-cycle commit returns old data
  always_comb begin
    rd_value = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (ridx == idx_t'(k)) rd_value = ctrl_o[k*DWIDTH +: DWIDTH];
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (ridx == idx_t'(NUM_RW + k)) rd_value = stat_i[k*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_reg   <= 1'b0;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= OKAY;
    end else begin
      ready_reg <= 1'b1;
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_ok ? OKAY : SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held_reg <= 1'b1;
          awaddr_reg  <= s_axil.awaddr;
        end
        if (w_hs) begin
          w_held_reg <= 1'b1;
          wdata_reg  <= s_axil.wdata;
          wstrb_reg  <= s_axil.wstrb;
        end
        if (bvalid_reg && s_axil.bready) bvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= OKAY;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_value;
      rresp_reg  <= rd_hit ? OKAY : SLVERR;
    end else if (rvalid_reg && s_axil.rready) begin
      rvalid_reg <= 1'b0;
    end
  end
endmodule
